// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: move sequencer for an external up/down position counter.
// Takes an absolute target over a valid/ready command port, then steps the
// counter one position per DIV clocks until count matches the target.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   cmd_valid     command present
//   cmd_ready     command accepted when cmd_valid && cmd_ready
//   cmd_target    requested absolute position (N bits)
//   abort         stop the current move at the next step boundary
//   count         current counter value fed back from the counter
//   en            counter enable, one cycle per step
//   cw            step direction, 1 = increment, 0 = decrement
//   busy          a move is in progress
//   done          one-cycle pulse when a move finishes or is aborted
//   err           one-cycle pulse when a command is rejected
//   steps         (COUNT_SEQ_STEPS_EN only) en pulses in current/last move
//
// Optional feature macro: COUNT_SEQ_STEPS_EN adds the steps output.

module count_seq_ctrl #(
    parameter int             N       = 20,
    parameter int             DIV     = 4,
    parameter logic [N-1:0]   MAX_POS = {N{1'b1}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [N-1:0]   cmd_target,
    input  logic           abort,
    input  logic [N-1:0]   count,
    output logic           en,
    output logic           cw,
    output logic           busy,
    output logic           done,
    output logic           err
`ifdef COUNT_SEQ_STEPS_EN
    ,
    output logic [N-1:0]   steps
`endif
);

    if (DIV < 2 || DIV > 65536) begin : g_bad_div
        $error("count_seq_ctrl: DIV must be in 2..65536");
    end

    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  MOVE   = 2'd1;
    localparam logic [1:0]  DONE   = 2'd2;

    localparam logic [15:0] RELOAD = 16'(DIV - 1);

    // One guard bit keeps the range check a real compare even when
    // MAX_POS is the all-ones default.
    localparam logic [N:0]  MAX_W  = {1'b0, MAX_POS};

    logic [1:0]   state;
    logic [1:0]   state_nx;
    logic [15:0]  presc;
    logic [N-1:0] target;
    logic         abort_q;

    logic         accept;
    logic         reject;
    logic         take;
    logic         expire;
    logic         stop;
    logic         step;

    assign accept = cmd_valid && (state == IDLE);
    assign reject = accept && ({1'b0, cmd_target} > MAX_W);
    assign take   = accept && !reject;

    // Step boundary: the only cycle on which count is compared.
    assign expire = (state == MOVE) && (presc == 16'd0);

    // An abort arriving on the boundary cycle itself also stops the move.
    assign stop   = (count == target) || abort_q || abort;
    assign step   = expire && !stop;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state == MOVE);
    assign done      = (state == DONE);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (take) state_nx = MOVE;
            MOVE:    if (expire && stop) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= 16'd0;
        end else if (take) begin
            presc <= RELOAD;
        end else if (state == MOVE) begin
            if (presc != 16'd0) begin
                presc <= presc - 16'd1;
            end else if (step) begin
                presc <= RELOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= '0;
        end else if (take) begin
            target <= cmd_target;
        end
    end

    // Sticky abort request; dropped when the move ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= (state == MOVE) && !(expire && stop)
                       && (abort_q || abort);
        end
    end

    // en and cw leave together; cw holds between steps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en <= 1'b0;
            cw <= 1'b0;
        end else begin
            en <= step;
            if (step) begin
                cw <= (target > count);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else begin
            err <= reject;
        end
    end

`ifdef COUNT_SEQ_STEPS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            steps <= '0;
        end else if (take) begin
            steps <= '0;
        end else if (step) begin
            steps <= steps + {{(N-1){1'b0}}, 1'b1};
        end
    end
`endif

endmodule

// File: tb/tb_count_seq_ctrl.sv
// tb_count_seq_ctrl: scoreboard bench for count_seq_ctrl.
// Directed moves; expected en/done/err events are queued and checked.

module tb_count_seq_ctrl;

    localparam int N      = 8;
    localparam int DIV    = 4;
    localparam int K_EN   = 0;
    localparam int K_DONE = 1;
    localparam int K_ERR  = 2;

    logic         clk;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [N-1:0] cmd_target;
    logic         abort;
    logic [N-1:0] count;
    logic         en;
    logic         cw;
    logic         busy;
    logic         done;
    logic         err;
`ifdef COUNT_SEQ_STEPS_EN
    logic [N-1:0] steps;
`endif

    logic         ld;
    logic [N-1:0] ld_val;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;

    typedef struct {
        int           kind;
        int           cyc;
        logic         cw;
        logic [N-1:0] cnt;
        int           nst;
    } ev_t;

    ev_t q[$];

    count_seq_ctrl #(
        .N       (N),
        .DIV     (DIV),
        .MAX_POS (8'd100)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_target (cmd_target),
        .abort      (abort),
        .count      (count),
        .en         (en),
        .cw         (cw),
        .busy       (busy),
        .done       (done),
        .err        (err)
`ifdef COUNT_SEQ_STEPS_EN
        ,
        .steps      (steps)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // The controlled up/down counter, with a preload for test setup.
    always @(posedge clk) begin
        if (ld) begin
            count <= ld_val;
        end else if (en) begin
            count <= cw ? count + 8'd1 : count - 8'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic push(input int k, input int c, input logic d,
                        input logic [N-1:0] v, input int s);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.cw   = d;
        e.cnt  = v;
        e.nst  = s;
        q.push_back(e);
    endtask

    // Monitor: every en/done/err pulse must match the queue head.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        if (!rst && (en || done || err)) begin
            k = err ? K_ERR : (done ? K_DONE : K_EN);
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: kind %0d at cycle %0d, none required",
                         k, cyc);
            end else begin
                e = q.pop_front();
                chk("event_kind", k, e.kind);
                chk("event_cycle", cyc, e.cyc);
                if (e.kind == K_EN) begin
                    chk("step_cw", int'(cw), int'(e.cw));
                end
                if (e.kind == K_DONE) begin
                    chk("done_count", int'(count), int'(e.cnt));
                    chk("done_busy", int'(busy), 0);
`ifdef COUNT_SEQ_STEPS_EN
                    chk("done_steps", int'(steps), e.nst);
`endif
                end
            end
        end
    end

    task automatic load(input logic [N-1:0] v);
        ld     = 1'b1;
        ld_val = v;
        @(posedge clk);
        #1;
        ld     = 1'b0;
    endtask

    task automatic issue(input logic [N-1:0] t, output int a);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid  = 1'b1;
        cmd_target = t;
        @(posedge clk);
        #1;
        a          = cyc;
        cmd_valid  = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_pending", q.size(), 0);
        chk("ready_after_done", int'(cmd_ready), 1);
        chk("busy_after_done", int'(busy), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_target = '0;
        abort      = 1'b0;
        ld         = 1'b0;
        ld_val     = '0;
        count      = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", int'(cmd_ready), 1);
        chk("rst_en", int'(en), 0);
        chk("rst_cw", int'(cw), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
`ifdef COUNT_SEQ_STEPS_EN
        chk("rst_steps", int'(steps), 0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Up move 0 -> 3.
        load(8'd0);
        issue(8'd3, a);
        push(K_EN, a + 4, 1'b1, '0, 0);
        push(K_EN, a + 8, 1'b1, '0, 0);
        push(K_EN, a + 12, 1'b1, '0, 0);
        push(K_DONE, a + 16, 1'b0, 8'd3, 3);
        chk("busy_in_move", int'(busy), 1);
        chk("ready_in_move", int'(cmd_ready), 0);
        wait_idle();

        // Down move 10 -> 7.
        load(8'd10);
        issue(8'd7, a);
        push(K_EN, a + 4, 1'b0, '0, 0);
        push(K_EN, a + 8, 1'b0, '0, 0);
        push(K_EN, a + 12, 1'b0, '0, 0);
        push(K_DONE, a + 16, 1'b0, 8'd7, 3);
        wait_idle();

        // Zero-length move.
        load(8'd5);
        issue(8'd5, a);
        push(K_DONE, a + 4, 1'b0, 8'd5, 0);
        wait_idle();

        // Reject above MAX_POS, then a legal command.
        issue(8'd101, a);
        push(K_ERR, a, 1'b0, '0, 0);
        chk("busy_on_reject", int'(busy), 0);
        chk("ready_on_reject", int'(cmd_ready), 1);
        wait_idle();
        load(8'd48);
        issue(8'd50, a);
        push(K_EN, a + 4, 1'b1, '0, 0);
        push(K_EN, a + 8, 1'b1, '0, 0);
        push(K_DONE, a + 12, 1'b0, 8'd50, 2);
        wait_idle();

        // Abort after the second step.
        load(8'd0);
        issue(8'd20, a);
        push(K_EN, a + 4, 1'b1, '0, 0);
        push(K_EN, a + 8, 1'b1, '0, 0);
        push(K_DONE, a + 12, 1'b0, 8'd2, 2);
        repeat (9) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        wait_idle();

        // Abort while idle is ignored.
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("idle_abort_busy", int'(busy), 0);

        // Reset in the middle of a step pulse.
        load(8'd0);
        issue(8'd20, a);
        push(K_EN, a + 4, 1'b1, '0, 0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_en", int'(en), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_ready", int'(cmd_ready), 1);
        chk("midrst_done", int'(done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("midrst_queue", q.size(), 0);
        chk("midrst_count", int'(count), 0);

        // Fresh command after reset.
        issue(8'd2, a);
        push(K_EN, a + 4, 1'b1, '0, 0);
        push(K_EN, a + 8, 1'b1, '0, 0);
        push(K_DONE, a + 12, 1'b0, 8'd2, 2);
        wait_idle();

        repeat (3) @(posedge clk);
        #1;
        chk("final_queue", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
